// File: rtl/axi4lite_apb_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_apb_bridge_pkg
// Purpose  : Shared widths, AMBA response codes and the APB master FSM state
//            encoding for the AXI4-Lite to APB4 bridge and later APB blocks.
// Contents : c_*_w bus widths, c_resp_okay / c_resp_slverr, apb_state_e,
//            resp_encode().
// Revision : 1.0 - initial release
// ============================================================================
package axi4lite_apb_bridge_pkg;

  localparam int c_addr_w = 32;
  localparam int c_data_w = 32;
  localparam int c_strb_w = 4;
  localparam int c_prot_w = 3;

  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  function automatic logic [1:0] resp_encode(input logic err);
    return err ? c_resp_slverr : c_resp_okay;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi4lite_apb_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_apb_bridge_if
// Purpose  : Bundles the AXI4-Lite slave channels and the APB4 master signals
//            seen by the bridge.
// Modports : slave  - the bridge: AXI4-Lite slave side plus APB request driver
//            master - the environment: AXI4-Lite master plus APB completer
// Revision : 1.0 - initial release
// ============================================================================
interface axi4lite_apb_bridge_if;
  import axi4lite_apb_bridge_pkg::*;

  // AW / W / B
  logic                awvalid;
  logic                awready;
  logic [c_addr_w-1:0] awaddr;
  logic [c_prot_w-1:0] awprot;
  logic                wvalid;
  logic                wready;
  logic [c_data_w-1:0] wdata;
  logic [c_strb_w-1:0] wstrb;
  logic                bvalid;
  logic                bready;
  logic [1:0]          bresp;
  // AR / R
  logic                arvalid;
  logic                arready;
  logic [c_addr_w-1:0] araddr;
  logic [c_prot_w-1:0] arprot;
  logic                rvalid;
  logic                rready;
  logic [c_data_w-1:0] rdata;
  logic [1:0]          rresp;
  // APB
  logic [c_addr_w-1:0] paddr;
  logic                psel;
  logic                penable;
  logic [c_prot_w-1:0] pprot;
  logic                pwrite;
  logic [c_data_w-1:0] pwdata;
  logic [c_strb_w-1:0] pstrb;
  logic                pready;
  logic [c_data_w-1:0] prdata;
  logic                pslverr;

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    input  pready, prdata, pslverr,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
    output paddr, psel, penable, pprot, pwrite, pwdata, pstrb
  );

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    output pready, prdata, pslverr,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
    input  paddr, psel, penable, pprot, pwrite, pwdata, pstrb
  );

endinterface
`default_nettype wire

// File: rtl/axi4lite_apb_bridge_hold_reg.sv
`default_nettype none
// ============================================================================
// Module   : axil_hold_reg
// Purpose  : One-entry valid/ready holding register for an AXI4-Lite request
//            channel. The entry may also be consumed in the cycle it arrives
//            (bypass), in which case it is never stored.
// Ports    : clock, reset      - clock, asynchronous active-high reset
//            i_valid/o_ready   - upstream handshake (ready = entry empty)
//            i_data            - upstream payload
//            o_valid/o_data    - entry (stored or arriving) available
//            i_take            - consumer frees the entry this cycle
// Revision : 1.0 - initial release
// ============================================================================
module axil_hold_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_take
);

  logic             r_armed;  // keeps ready low during and at release of reset
  logic             r_full;
  logic [WIDTH-1:0] r_data;
  logic             w_fire;

  assign o_ready = r_armed & ~r_full;
  assign w_fire  = i_valid & o_ready;
  assign o_valid = r_full | w_fire;
  assign o_data  = r_full ? r_data : i_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_armed <= 1'b0;
      r_full  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_armed <= 1'b1;
      if (i_take) begin
        // Consuming an arriving beat in the same cycle means it is never stored.
        r_full <= 1'b0;
      end else if (w_fire) begin
        r_full <= 1'b1;
        r_data <= i_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi4lite_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_apb_bridge
// Purpose  : Converts AXI4-Lite reads and writes into single APB4 transfers,
//            one at a time, alternating reads and writes under contention.
//            An optional ACCESS-phase timeout turns a hung completer into a
//            SLVERR response.
// Ports    : clock, reset - clock, asynchronous active-high reset
//            bus          - AXI4-Lite slave channels and APB4 master signals
// Params   : TIMEOUT      - ACCESS-cycle limit, 0 disables the timeout
// Revision : 1.0 - initial release
// ============================================================================
module axi4lite_apb_bridge
  import axi4lite_apb_bridge_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  axi4lite_apb_bridge_if.slave bus
);

  localparam int c_aw_w = c_prot_w + c_addr_w;
  localparam int c_w_w  = c_strb_w + c_data_w;

  apb_state_e          r_state;
  apb_state_e          w_next;
  logic                r_armed;
  logic                r_last_write;
  logic                r_is_write;
  logic [c_addr_w-1:0] r_paddr;
  logic [c_prot_w-1:0] r_pprot;
  logic [c_data_w-1:0] r_pwdata;
  logic [c_strb_w-1:0] r_pstrb;
  logic [c_data_w-1:0] r_rdata;
  logic [1:0]          r_resp;

  logic                w_awready;
  logic                w_wready;
  logic                w_arready;
  logic                w_aw_valid;
  logic                w_w_valid;
  logic [c_aw_w-1:0]   w_aw_data;
  logic [c_w_w-1:0]    w_w_data;
  logic                w_wr_avail;
  logic                w_is_idle;
  logic                w_grant_rd;
  logic                w_grant_wr;
  logic                w_done;
  logic                w_timeout;
  logic                w_rsp_fire;

  // --------------------------------------------------------------------------
  // Write request holding entries (AW and W independent)
  // --------------------------------------------------------------------------
  axil_hold_reg #(.WIDTH(c_aw_w)) u_aw_hold (
    .clock   (clock),
    .reset   (reset),
    .i_valid (bus.awvalid),
    .o_ready (w_awready),
    .i_data  ({bus.awprot, bus.awaddr}),
    .o_valid (w_aw_valid),
    .o_data  (w_aw_data),
    .i_take  (w_grant_wr)
  );

  axil_hold_reg #(.WIDTH(c_w_w)) u_w_hold (
    .clock   (clock),
    .reset   (reset),
    .i_valid (bus.wvalid),
    .o_ready (w_wready),
    .i_data  ({bus.wstrb, bus.wdata}),
    .o_valid (w_w_valid),
    .o_data  (w_w_data),
    .i_take  (w_grant_wr)
  );

  // --------------------------------------------------------------------------
  // Arbitration: a write counts as pending as soon as its later half arrives,
  // so write latency matches read latency from the final handshake.
  // --------------------------------------------------------------------------
  assign w_is_idle  = r_armed & (r_state == ST_IDLE);
  assign w_wr_avail = w_aw_valid & w_w_valid;
  assign w_arready  = w_is_idle & (~w_wr_avail | r_last_write);
  assign w_grant_rd = bus.arvalid & w_arready;
  assign w_grant_wr = w_is_idle & w_wr_avail & ~w_grant_rd;
  assign w_done     = (r_state == ST_ACCESS) & (bus.pready | w_timeout);
  assign w_rsp_fire = (r_state == ST_RESP) & (r_is_write ? bus.bready : bus.rready);

  // --------------------------------------------------------------------------
  // ACCESS-phase timeout
  // --------------------------------------------------------------------------
  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam int c_cnt_w = $clog2(TIMEOUT + 1);
      localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT - 1);
      logic [c_cnt_w-1:0] r_count;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_count <= '0;
        end else if (r_state == ST_SETUP) begin
          r_count <= '0;
        end else if ((r_state == ST_ACCESS) && !bus.pready) begin
          r_count <= r_count + 1'b1;
        end
      end

      // A pready in the limit cycle wins and completes normally.
      assign w_timeout = (r_state == ST_ACCESS) & ~bus.pready & (r_count == c_limit);
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // APB master FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_next;
      r_armed <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_grant_rd || w_grant_wr) w_next = ST_SETUP;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: if (w_done) w_next = ST_RESP;
      ST_RESP:   if (w_rsp_fire) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_write <= 1'b0;
      r_is_write   <= 1'b0;
      r_paddr      <= '0;
      r_pprot      <= '0;
      r_pwdata     <= '0;
      r_pstrb      <= '0;
      r_rdata      <= '0;
      r_resp       <= c_resp_okay;
    end else begin
      if (w_grant_rd) begin
        r_is_write   <= 1'b0;
        r_last_write <= 1'b0;
        r_paddr      <= bus.araddr;
        r_pprot      <= bus.arprot;
        r_pwdata     <= '0;
        r_pstrb      <= '0;
      end else if (w_grant_wr) begin
        r_is_write   <= 1'b1;
        r_last_write <= 1'b1;
        r_paddr      <= w_aw_data[c_addr_w-1:0];
        r_pprot      <= w_aw_data[c_aw_w-1:c_addr_w];
        r_pwdata     <= w_w_data[c_data_w-1:0];
        r_pstrb      <= w_w_data[c_w_w-1:c_data_w];
      end
      if (w_done) begin
        r_resp  <= resp_encode(w_timeout | bus.pslverr);
        r_rdata <= w_timeout ? '0 : bus.prdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.awready = w_awready;
  assign bus.wready  = w_wready;
  assign bus.arready = w_arready;
  assign bus.psel    = (r_state == ST_SETUP) | (r_state == ST_ACCESS);
  assign bus.penable = (r_state == ST_ACCESS);
  assign bus.paddr   = r_paddr;
  assign bus.pprot   = r_pprot;
  assign bus.pwrite  = r_is_write;
  assign bus.pwdata  = r_pwdata;
  assign bus.pstrb   = r_pstrb;
  assign bus.bvalid  = (r_state == ST_RESP) & r_is_write;
  assign bus.rvalid  = (r_state == ST_RESP) & ~r_is_write;
  assign bus.bresp   = r_resp;
  assign bus.rresp   = r_resp;
  assign bus.rdata   = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4lite_apb_bridge
// Purpose  : Directed self-checking bench for axi4lite_apb_bridge. An APB
//            completer model answers transfers; a transaction-level model
//            predicts each APB request and AXI response, and a compare process
//            checks the bus every cycle against those predictions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4lite_apb_bridge;

  localparam int TIMEOUT = 8;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [2:0]  prot;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } req_t;

  typedef struct {
    logic        w;
    logic [1:0]  resp;
    logic [31:0] data;
  } rsp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  bit   grant_log[$];
  int   n_rsp_done = 0;
  int   last_acc_cycles = 0;
  logic [31:0] seen_paddr;
  logic [3:0]  seen_pstrb;

  // completer configuration
  int          slv_wait   = 0;
  bit          slv_never  = 0;
  bit          slv_err    = 0;
  logic [31:0] slv_prdata = '0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  axi4lite_apb_bridge_if bus ();

  axi4lite_apb_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // APB completer: pready after slv_wait low ACCESS cycles, or never.
  // --------------------------------------------------------------------------
  initial begin
    int sk;
    sk = 0;
    bus.pready  = 1'b0;
    bus.prdata  = '0;
    bus.pslverr = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        sk = 0;
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
      end else if (bus.psel && bus.penable) begin
        bus.pready  = !slv_never && (sk == slv_wait);
        bus.prdata  = slv_prdata;
        bus.pslverr = slv_err;
        sk++;
      end else begin
        sk = 0;
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        bus.prdata  = '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Compare process: checks every cycle against the expected queues.
  // --------------------------------------------------------------------------
  initial begin
    bit   prev_psel;
    int   low;
    int   acc_k;
    bit   timed;
    req_t r;
    rsp_t s;
    rsp_t ns;
    prev_psel = 0;
    low = 100;
    acc_k = 0;
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        exp_req.delete();
        exp_rsp.delete();
        prev_psel = 0;
        low = 100;
        acc_k = 0;
      end else begin
        if (bus.psel) begin
          check("psel_expected", exp_req.size() != 0, 1);
          if (exp_req.size() != 0) begin
            r = exp_req[0];
            check("paddr", bus.paddr, r.addr);
            check("pprot", bus.pprot, r.prot);
            check("pwrite", bus.pwrite, r.w);
            check("pwdata", bus.pwdata, r.wdata);
            check("pstrb", bus.pstrb, r.strb);
            seen_paddr = bus.paddr;
            seen_pstrb = bus.pstrb;
            if (!prev_psel) begin
              check("setup_penable", bus.penable, 0);
              check("psel_gap", low >= 2, 1);
              grant_log.push_back(bus.pwrite);
            end else begin
              check("access_penable", bus.penable, 1);
            end
            if (bus.penable) begin
              timed = !bus.pready && (acc_k == TIMEOUT - 1);
              if (bus.pready || timed) begin
                ns.w    = r.w;
                ns.resp = (timed || bus.pslverr) ? 2'b10 : 2'b00;
                ns.data = timed ? 32'h0 : bus.prdata;
                exp_rsp.push_back(ns);
                void'(exp_req.pop_front());
                last_acc_cycles = acc_k + 1;
                acc_k = 0;
              end else begin
                acc_k++;
              end
            end
          end
          low = 0;
        end else begin
          low++;
          acc_k = 0;
        end
        prev_psel = bus.psel;

        if (bus.bvalid || bus.rvalid) begin
          check("rsp_expected", exp_rsp.size() != 0, 1);
          if (exp_rsp.size() != 0) begin
            s = exp_rsp[0];
            check("bvalid_kind", bus.bvalid, s.w);
            check("rvalid_kind", bus.rvalid, !s.w);
            if (s.w) begin
              check("bresp", bus.bresp, s.resp);
            end else begin
              check("rresp", bus.rresp, s.resp);
              check("rdata", bus.rdata, s.data);
            end
            if ((bus.bvalid && bus.bready) || (bus.rvalid && bus.rready)) begin
              void'(exp_rsp.pop_front());
              n_rsp_done++;
            end
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed transaction tasks (start and end on a falling edge)
  // --------------------------------------------------------------------------
  task automatic read_txn(input logic [31:0] addr, input logic [2:0] prot,
                          input logic [31:0] data, input int wait_n, input bit never,
                          output logic [31:0] got_data, output logic [1:0] got_resp);
    int k;
    int t0;
    slv_wait = wait_n; slv_never = never; slv_prdata = data; slv_err = 0;
    exp_req.push_back('{w: 1'b0, addr: addr, prot: prot, wdata: 32'h0, strb: 4'h0});
    bus.rready = 1'b0;
    bus.arvalid = 1'b1; bus.araddr = addr; bus.arprot = prot;
    k = 0;
    #1;
    while (!bus.arready && k < 50) begin
      @(negedge clock); #1; k++;
    end
    check("ar_handshake", bus.arready, 1);
    t0 = cyc;
    @(negedge clock);
    bus.arvalid = 1'b0;
    #1;
    k = 0;
    while (!bus.rvalid && k < 40) begin
      @(negedge clock); #1; k++;
    end
    check("rvalid_seen", bus.rvalid, 1);
    check("read_latency", cyc - t0, never ? 2 + TIMEOUT : 3 + wait_n);
    got_data = bus.rdata;
    got_resp = bus.rresp;
    bus.rready = 1'b1;
    @(negedge clock);
    bus.rready = 1'b0;
    #1;
    check("rvalid_dropped", bus.rvalid, 0);
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [2:0] prot,
                           input logic [31:0] data, input logic [3:0] strb,
                           input int w_lead, input int wait_n, input bit err,
                           input int bready_hold, output logic [1:0] got_resp);
    int k;
    int t_aw;
    int t_w;
    int t_last;
    bit aw_done;
    bit w_done;
    slv_wait = wait_n; slv_never = 0; slv_prdata = 32'h0; slv_err = err;
    exp_req.push_back('{w: 1'b1, addr: addr, prot: prot, wdata: data, strb: strb});
    bus.bready = 1'b0;
    bus.awaddr = addr; bus.awprot = prot; bus.wdata = data; bus.wstrb = strb;
    t_aw = (w_lead >= 0) ? w_lead : 0;
    t_w  = (w_lead >= 0) ? 0 : -w_lead;
    aw_done = 0; w_done = 0; k = 0; t_last = 0;
    while (!(aw_done && w_done) && k < 30) begin
      bus.awvalid = !aw_done && (k >= t_aw);
      bus.wvalid  = !w_done && (k >= t_w);
      #1;
      if (bus.awvalid && bus.awready) aw_done = 1;
      if (bus.wvalid && bus.wready) w_done = 1;
      if (aw_done && w_done) t_last = cyc;
      @(negedge clock);
      k++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check("wr_handshake", aw_done && w_done, 1);
    #1;
    k = 0;
    while (!bus.bvalid && k < 40) begin
      @(negedge clock); #1; k++;
    end
    check("bvalid_seen", bus.bvalid, 1);
    check("write_latency", cyc - t_last, 3 + wait_n);
    got_resp = bus.bresp;
    for (int i = 0; i < bready_hold; i++) begin
      @(negedge clock); #1;
      check("bvalid_held", bus.bvalid, 1);
      check("bresp_held", bus.bresp, got_resp);
    end
    bus.bready = 1'b1;
    @(negedge clock);
    bus.bready = 1'b0;
    #1;
    check("bvalid_dropped", bus.bvalid, 0);
  endtask

  task automatic wait_rsps(input int target);
    int k;
    k = 0;
    while (n_rsp_done < target && k < 60) begin
      @(negedge clock); k++;
    end
    check("rsps_completed", n_rsp_done >= target, 1);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    logic [31:0] d;
    logic [1:0]  rs;
    int          k;
    int          base;

    bus.awvalid = 0; bus.awaddr = '0; bus.awprot = '0;
    bus.wvalid  = 0; bus.wdata  = '0; bus.wstrb  = '0; bus.bready = 0;
    bus.arvalid = 0; bus.araddr = '0; bus.arprot = '0; bus.rready = 0;

    // reset values
    @(negedge clock); #1;
    check("rst_awready", bus.awready, 0);
    check("rst_wready", bus.wready, 0);
    check("rst_arready", bus.arready, 0);
    check("rst_psel", bus.psel, 0);
    check("rst_penable", bus.penable, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_paddr", bus.paddr, 0);
    check("rst_rdata", bus.rdata, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock); #1;
    check("post_rst_awready", bus.awready, 1);
    check("post_rst_wready", bus.wready, 1);
    check("post_rst_arready", bus.arready, 1);
    @(negedge clock);

    // single zero-wait read
    read_txn(32'h0000_1000, 3'b000, 32'hDEADBEEF, 0, 0, d, rs);
    check("t1_rdata", d, 32'hDEADBEEF);
    check("t1_rresp", rs, 2'b00);
    @(negedge clock);

    // read and write contend, last grant was read -> write first
    slv_wait = 1; slv_never = 0; slv_err = 0; slv_prdata = 32'hCAFEF00D;
    exp_req.push_back('{w: 1'b1, addr: 32'h2000_0008, prot: 3'b010, wdata: 32'h1122_3344, strb: 4'hF});
    exp_req.push_back('{w: 1'b0, addr: 32'h3000_000C, prot: 3'b001, wdata: 32'h0, strb: 4'h0});
    grant_log.delete();
    base = n_rsp_done;
    bus.bready = 1; bus.rready = 1;
    bus.awvalid = 1; bus.awaddr = 32'h2000_0008; bus.awprot = 3'b010;
    bus.wvalid = 1; bus.wdata = 32'h1122_3344; bus.wstrb = 4'hF;
    bus.arvalid = 1; bus.araddr = 32'h3000_000C; bus.arprot = 3'b001;
    #1;
    check("arb1_arready_low", bus.arready, 0);
    @(negedge clock);
    bus.awvalid = 0; bus.wvalid = 0;
    #1;
    k = 0;
    while (!bus.arready && k < 40) begin
      @(negedge clock); #1; k++;
    end
    check("arb1_ar_accepted", bus.arready, 1);
    @(negedge clock);
    bus.arvalid = 0;
    wait_rsps(base + 2);
    bus.bready = 0; bus.rready = 0;
    check("arb1_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("arb1_first_is_write", grant_log[0], 1);
      check("arb1_second_is_read", grant_log[1], 0);
    end
    @(negedge clock);

    // W two cycles ahead of AW
    write_txn(32'h1000_0004, 3'b000, 32'hFEEDFACE, 4'b0011, 2, 0, 0, 0, rs);
    check("t2_bresp", rs, 2'b00);
    check("t2_paddr", seen_paddr, 32'h1000_0004);
    check("t2_pstrb", seen_pstrb, 4'b0011);
    @(negedge clock);

    // contention after a write -> read first
    slv_wait = 0; slv_never = 0; slv_err = 0; slv_prdata = 32'h0BEE_F00D;
    exp_req.push_back('{w: 1'b0, addr: 32'h3000_0010, prot: 3'b000, wdata: 32'h0, strb: 4'h0});
    exp_req.push_back('{w: 1'b1, addr: 32'h2000_0020, prot: 3'b000, wdata: 32'h5566_7788, strb: 4'b1100});
    grant_log.delete();
    base = n_rsp_done;
    bus.bready = 1; bus.rready = 1;
    bus.awvalid = 1; bus.awaddr = 32'h2000_0020; bus.awprot = 3'b000;
    bus.wvalid = 1; bus.wdata = 32'h5566_7788; bus.wstrb = 4'b1100;
    bus.arvalid = 1; bus.araddr = 32'h3000_0010; bus.arprot = 3'b000;
    #1;
    check("arb2_arready_high", bus.arready, 1);
    @(negedge clock);
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    wait_rsps(base + 2);
    bus.bready = 0; bus.rready = 0;
    check("arb2_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("arb2_first_is_read", grant_log[0], 0);
      check("arb2_second_is_write", grant_log[1], 1);
    end
    @(negedge clock);

    // slave error on a write, bready held low for 5 cycles
    write_txn(32'h4000_0010, 3'b000, 32'hA5A5_A5A5, 4'hF, -1, 2, 1, 5, rs);
    check("t5_bresp", rs, 2'b10);
    @(negedge clock);

    // hung slave -> timeout
    read_txn(32'h5000_0000, 3'b011, 32'h55AA_55AA, 0, 1, d, rs);
    check("t4_rresp", rs, 2'b10);
    check("t4_rdata", d, 32'h0);
    check("t4_access_cycles", last_acc_cycles, 8);
    check("t4_back_to_idle", bus.arready, 1);
    @(negedge clock);

    // read with wait states
    read_txn(32'h6000_0040, 3'b101, 32'h1234_5678, 3, 0, d, rs);
    check("t8_rdata", d, 32'h1234_5678);
    check("t8_access_cycles", last_acc_cycles, 4);
    @(negedge clock);

    // reset while in ACCESS
    slv_wait = 0; slv_never = 1; slv_err = 0; slv_prdata = 32'h0;
    exp_req.push_back('{w: 1'b0, addr: 32'h7000_0000, prot: 3'b000, wdata: 32'h0, strb: 4'h0});
    bus.arvalid = 1; bus.araddr = 32'h7000_0000; bus.arprot = 3'b000;
    #1;
    k = 0;
    while (!bus.arready && k < 20) begin
      @(negedge clock); #1; k++;
    end
    @(negedge clock);
    bus.arvalid = 0;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock); #1;
    check("t6_in_access", bus.penable, 1);
    reset = 1'b1;
    #1;
    check("t6_psel_drop", bus.psel, 0);
    check("t6_penable_drop", bus.penable, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    slv_never = 0;
    bus.rready = 1; bus.bready = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); #1;
      check("t6_no_rvalid", bus.rvalid, 0);
      check("t6_no_bvalid", bus.bvalid, 0);
    end
    bus.rready = 0; bus.bready = 0;
    @(negedge clock);

    // recovery after reset
    read_txn(32'h8000_0004, 3'b000, 32'h0BAD_F00D, 0, 0, d, rs);
    check("t7_rdata", d, 32'h0BAD_F00D);
    check("t7_rresp", rs, 2'b00);

    repeat (3) @(negedge clock);
    check("no_pending_req", exp_req.size(), 0);
    check("no_pending_rsp", exp_rsp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
